// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus arbiter: device ids, FSM state, latched command, decode helpers.
package mmio_pkg;

  localparam logic [3:0] DEV_DMEM    = 4'h1;
  localparam logic [3:0] DEV_SEG     = 4'h2;
  localparam logic [3:0] DEV_TIMER   = 4'h3;
  localparam logic [3:0] DEV_CMEM    = 4'h4;
  localparam logic [3:0] DEV_KBD     = 4'h5;
  localparam logic [3:0] DEV_SW      = 4'h6;
  localparam logic [3:0] DEV_LED     = 4'h7;
  localparam logic [3:0] DEV_FB      = 4'h8;
  localparam logic [3:0] DEV_VGAMODE = 4'he;
  localparam logic [3:0] DEV_SERIAL  = 4'hf;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mmio_cmd_t;

  function automatic logic dev_mapped(input logic [3:0] id);
    return id inside {DEV_DMEM, DEV_SEG, DEV_TIMER, DEV_CMEM, DEV_KBD,
                      DEV_SW, DEV_LED, DEV_FB, DEV_VGAMODE, DEV_SERIAL};
  endfunction

  // Everything mapped but not listed here is write-only.
  function automatic logic dev_readable(input logic [3:0] id);
    return id inside {DEV_DMEM, DEV_TIMER, DEV_KBD, DEV_SW};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on a tie the input that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       which
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    which = 1'b0;
    grant = 2'b00;
    case (req)
      2'b01:   which = 1'b0;
      2'b10:   which = 1'b1;
      2'b11:   which = ~last;
      default: which = 1'b0;
    endcase
    if (req != 2'b00) grant[which] = 1'b1;
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master MMIO bus arbiter with per-device wait states and one write strobe per store.
// Optional build macro MMIO_ERR_EN: unmapped ids and loads from write-only ids respond with err=1.
module mmio_bus_arbiter
  import mmio_pkg::*;
#(
  parameter int WAIT_DMEM  = 1,
  parameter int WAIT_FB    = 1,
  parameter int WAIT_OTHER = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic [31:0] bus_rdata
);

  arb_state_t       state_q, state_d;
  mmio_cmd_t        cmd_q, cmd_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [1:0]       pick_gnt;
  logic             pick_which;
  mmio_cmd_t        win_cmd;
  logic [3:0]       win_id;

  function automatic logic [CNT_W-1:0] wait_of(input logic [3:0] id);
    case (id)
      DEV_DMEM: return CNT_W'(WAIT_DMEM);
      DEV_FB:   return CNT_W'(WAIT_FB);
      default:  return CNT_W'(WAIT_OTHER);
    endcase
  endfunction

  rr_arb2 u_rr (
    .req   ({m1_req, m0_req}),
    .last  (last_q),
    .grant (pick_gnt),
    .which (pick_which)
  );

  assign win_cmd = pick_which ? '{m1_we, m1_addr, m1_wdata, m1_wmask}
                              : '{m0_we, m0_addr, m0_wdata, m0_wmask};
  assign win_id  = win_cmd.addr[23:20];

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    owner_d = owner_q;
    last_d  = last_q;
    first_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_gnt != 2'b00) begin
          cmd_d   = win_cmd;
          owner_d = pick_which;
          last_d  = pick_which;
          cnt_d   = wait_of(win_id);
          first_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = ACCESS;
`ifdef MMIO_ERR_EN
          if (!dev_mapped(win_id)) begin
            first_d = 1'b0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!win_cmd.we && !dev_readable(win_id)) begin
            err_d = 1'b1;
          end
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d = (cmd_q.we || err_q) ? '0 : bus_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      first_q <= first_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Grant is combinational from req so it lands in the same cycle; rst masks it.
  assign m0_gnt    = (state_q == IDLE) && !rst && pick_gnt[0];
  assign m1_gnt    = (state_q == IDLE) && !rst && pick_gnt[1];
  assign m0_rvalid = (state_q == RESP) && !owner_q;
  assign m1_rvalid = (state_q == RESP) &&  owner_q;
  assign m0_rdata  = m0_rvalid ? rdata_q : '0;
  assign m1_rdata  = m1_rvalid ? rdata_q : '0;

`ifdef MMIO_ERR_EN
  assign m0_err = m0_rvalid & err_q;
  assign m1_err = m1_rvalid & err_q;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  assign bus_addr  = cmd_q.addr;
  assign bus_we    = (state_q == ACCESS) && first_q && cmd_q.we;
  assign bus_wdata = cmd_q.wdata;
  assign bus_wmask = cmd_q.wmask;

  a_m0_hold: assert property (@(posedge clk) disable iff (rst) (m0_req && !m0_gnt) |=> m0_req);
  a_m1_hold: assert property (@(posedge clk) disable iff (rst) (m1_req && !m1_gnt) |=> m1_req);
  a_one_gnt: assert property (@(posedge clk) !(m0_gnt && m1_gnt));

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter: directed scenarios plus random single-master transactions.
module tb_mmio_bus_arbiter;

`ifdef MMIO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int W_DMEM = 1, W_FB = 1, W_OTHER = 0;

  logic        clk = 1'b0, rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, bus_we;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wmask;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mmio_bus_arbiter #(.WAIT_DMEM(W_DMEM), .WAIT_FB(W_FB), .WAIT_OTHER(W_OTHER)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rdata(bus_rdata)
  );

  // Reference rules for the address map.
  function automatic bit is_mapped(input logic [3:0] id);
    return id inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'he, 4'hf};
  endfunction

  function automatic bit is_readable(input logic [3:0] id);
    return id inside {4'h1, 4'h3, 4'h5, 4'h6};
  endfunction

  function automatic int w_of(input logic [3:0] id);
    return (id == 4'h1) ? W_DMEM : (id == 4'h8) ? W_FB : W_OTHER;
  endfunction

  // Decoder model: fixed word at one dmem address, address-derived data elsewhere, 0 when unmapped.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h0010_0004) return 32'hDEAD_BEEF;
    if (!is_mapped(a[23:20])) return 32'h0;
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  assign bus_rdata = rd_model(bus_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask);
    if (!m) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wmask = wmask;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wmask = wmask;
    end
  endtask

  function automatic logic gnt_of(input bit m);    return m ? m1_gnt : m0_gnt;       endfunction
  function automatic logic rvalid_of(input bit m); return m ? m1_rvalid : m0_rvalid; endfunction

  // One transaction from an idle arbiter; called just after a rising edge.
  task automatic txn(input bit m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask);
    logic [3:0]  id;
    bit          exp_err, skip;
    int          exp_lat, lat, pulses, we_cyc, stray;
    logic [31:0] exp_rd, got_rd, got_wd, got_addr;
    logic [3:0]  got_wm;
    logic        got_err;
    id      = addr[23:20];
    skip    = ERR_EN && !is_mapped(id);
    exp_err = ERR_EN && (!is_mapped(id) || (!we && !is_readable(id)));
    exp_lat = skip ? 1 : w_of(id) + 2;
    exp_rd  = (we || exp_err) ? 32'h0 : rd_model(addr);
    lat = 0; pulses = 0; we_cyc = 0; stray = 0;
    got_rd = 'x; got_err = 'x; got_wd = 'x; got_wm = 'x; got_addr = 'x;
    drive(m, 1'b1, we, addr, wdata, wmask);
    @(negedge clk);
    check("gnt_same_cycle", gnt_of(m), 1'b1);
    check("gnt_non_owner", gnt_of(!m), 1'b0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(m, 1'b0, we, addr, wdata, wmask);
      @(negedge clk);
      if (bus_we) begin
        pulses++;
        if (pulses == 1) begin we_cyc = c; got_wd = bus_wdata; got_wm = bus_wmask; end
      end
      if (rvalid_of(!m) || gnt_of(!m) || gnt_of(m)) stray++;
      if (rvalid_of(m)) begin
        lat = c; got_rd = m ? m1_rdata : m0_rdata; got_err = m ? m1_err : m0_err; got_addr = bus_addr;
        break;
      end
    end
    check("rvalid_latency", lat, exp_lat);
    check("rdata", got_rd, exp_rd);
    check("err", got_err, exp_err);
    check("bus_addr_held", got_addr, addr);
    check("we_pulses", pulses, (we && !skip) ? 1 : 0);
    check("stray_gnt_rvalid", stray, 0);
    if (we && !skip) begin
      check("we_cycle", we_cyc, 1);
      check("we_wdata", got_wd, wdata);
      check("we_wmask", got_wm, wmask);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int ng, overlap, evt;
    bit exp_next, last_g;
    logic [3:0] ids [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'he, 4'hf, 4'h0, 4'h9};

    // Reset state, with requests already pending during reset.
    #12;
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_wmask", bus_wmask, 4'h0);
    drive(0, 1'b1, 1'b1, 32'h0020_0010, 32'h1111_0000, 4'h1);
    drive(1, 1'b1, 1'b0, 32'h0030_0000, 32'h0, 4'h0);
    #1;
    check("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
    check("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    check("rst_err", {m1_err, m0_err}, 2'b00);

    // Both masters request continuously: grants alternate starting with m0.
    @(posedge clk); #1; rst = 1'b0;
    ng = 0; overlap = 0; exp_next = 1'b0; last_g = 1'b0;
    for (int c = 0; c < 200 && ng < 6; c++) begin
      @(negedge clk);
      if (m0_gnt && m1_gnt) overlap++;
      if (m0_rvalid || m1_rvalid) begin
        check("rr_rvalid_owner", {m1_rvalid, m0_rvalid}, last_g ? 2'b10 : 2'b01);
        if (m1_rvalid) check("rr_m1_rdata", m1_rdata, rd_model(32'h0030_0000));
      end
      if (m0_gnt || m1_gnt) begin
        check("rr_gnt_order", m1_gnt, exp_next);
        last_g = m1_gnt; exp_next = !exp_next; ng++;
      end
      @(posedge clk); #1;
    end
    check("rr_grant_count", ng, 6);
    check("rr_overlap", overlap, 0);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios.
    txn(0, 1'b0, 32'h0010_0004, 32'h0, 4'h0);
    txn(1, 1'b1, 32'h0020_0000, 32'h0000_1234, 4'hF);
    txn(0, 1'b0, 32'h0090_0000, 32'h0, 4'h0);
    txn(0, 1'b0, 32'h0070_0000, 32'h0, 4'h0);
    txn(1, 1'b0, 32'h0080_0100, 32'h0, 4'h0);

    // Random single-master traffic against the reference rules.
    for (int i = 0; i < 24; i++) begin
      logic [3:0] id;
      id = ids[$urandom_range(11)];
      txn(bit'($urandom_range(1)), logic'($urandom_range(1)),
          {8'h00, id, 20'($urandom)}, $urandom, 4'($urandom_range(15)));
    end

    // Reset in the second ACCESS cycle of a store, after its strobe.
    drive(0, 1'b1, 1'b1, 32'h0010_0040, 32'hCAFE_F00D, 4'h3);
    @(negedge clk);
    check("abort_gnt", m0_gnt, 1'b1);
    @(posedge clk); #1; drive(0, 1'b0, 1'b1, 32'h0010_0040, 32'hCAFE_F00D, 4'h3);
    @(negedge clk);
    check("abort_we_first", bus_we, 1'b1);
    @(posedge clk); #1; rst = 1'b1; #1;
    check("abort_bus_addr", bus_addr, 32'h0);
    check("abort_bus_we", bus_we, 1'b0);
    check("abort_bus_wdata", bus_wdata, 32'h0);
    check("abort_bus_wmask", bus_wmask, 4'h0);
    check("abort_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
    evt = 0;
    repeat (3) begin
      @(negedge clk);
      if (m0_rvalid || m1_rvalid || bus_we) evt++;
    end
    check("abort_no_activity", evt, 0);
    @(posedge clk); #1; rst = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0030_0000, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h0050_0000, 32'h0, 4'h0);
    @(negedge clk);
    check("post_rst_winner", {m1_gnt, m0_gnt}, 2'b01);
    @(posedge clk); #1; rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
